// File: rtl/instr_encoder.sv
// instr_encoder: packs symbolic instructions into 9-bit words and writes them to instruction memory
// Ports: clk/reset (async active-high); start+base_addr begin a load; in_valid/in_ready with
// in_mnem/in_rs/in_rt/in_rd/in_imm carry one instruction; imem_we/imem_addr/imem_wdata drive the
// memory write port; busy/done/err/err_code/word_count report load status.
// Build option: INSTR_ENC_RANGE_CHECK_EN enables operand range checking (err_code 2).
module instr_encoder #(
  parameter int NUM_REGS    = 12,
  parameter int INSTR_WIDTH = 9,
  parameter int PC_WIDTH    = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [PC_WIDTH-1:0]           base_addr,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [4:0]                    in_mnem,
  input  logic [$clog2(NUM_REGS)-1:0]   in_rs,
  input  logic [$clog2(NUM_REGS)-1:0]   in_rt,
  input  logic [$clog2(NUM_REGS)-1:0]   in_rd,
  input  logic [5:0]                    in_imm,
  output logic                          imem_we,
  output logic [PC_WIDTH-1:0]           imem_addr,
  output logic [INSTR_WIDTH-1:0]        imem_wdata,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [1:0]                    err_code,
  output logic [PC_WIDTH:0]             word_count
);
  localparam logic [INSTR_WIDTH-1:0] HALT = 9'b111_0000_11;
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE, ERR} state_t;
  state_t state_q, state_d;
  logic [PC_WIDTH-1:0] addr_q, addr_d;
  logic [INSTR_WIDTH-1:0] word_q, word_d, enc;
  logic [PC_WIDTH:0] cnt_q, cnt_d;
  logic [1:0] code_q, code_d;
  logic mnem_bad, range_bad;
  logic [3:0] rs_m4, rs_m5, rd_m8, rt_m8, rd_m1;
  logic [4:0] m13;
  assign rs_m4 = in_rs - 4'd4;
  assign rs_m5 = in_rs - 4'd5;
  assign rd_m8 = in_rd - 4'd8;
  assign rt_m8 = in_rt - 4'd8;
  assign rd_m1 = in_rd - 4'd1;
  assign m13 = in_mnem - 5'd13;
  assign mnem_bad = in_mnem > 5'd16;
  always_comb begin
    enc = '0;
    case (in_mnem)
      5'd0, 5'd1, 5'd2:    enc = {3'b000, rs_m4[1:0], in_rt[1:0], in_mnem[1:0]};
      5'd3:                enc = {3'b000, in_rs[1:0], rt_m8[1:0], 2'b11};
      5'd4:                enc = {3'b001, rs_m4[1:0], in_rd[1:0], 2'b00};
      5'd5:                enc = {3'b001, rs_m4[1:0], in_rt[1:0], 2'b01};
      5'd6:                enc = {3'b001, in_rs, 2'b10};
      5'd7:                enc = {3'b001, in_rd, 2'b11};
      5'd8, 5'd10:         enc = {in_mnem[1] ? 3'b100 : 3'b010, rs_m4[1:0], in_rt[1:0], rd_m8[1:0]};
      5'd9:                enc = {3'b011, rd_m8[1:0], in_rs[1:0], in_imm[1:0]};
      5'd11:               enc = {3'b101, rd_m1[2:0], rs_m5[2:0]};
      5'd12:               enc = {3'b110, in_imm};
      5'd13, 5'd14, 5'd15: enc = {3'b111, rs_m4[1:0], in_rt[1:0], m13[1:0]};
      5'd16:               enc = HALT;
      default:             enc = '0;
    endcase
  end
`ifdef INSTR_ENC_RANGE_CHECK_EN
  // Only operands the format actually uses are checked.
  always_comb begin
    range_bad = 1'b0;
    case (in_mnem)
      5'd0, 5'd1, 5'd2, 5'd5, 5'd13, 5'd14, 5'd15:
                  range_bad = in_rs[3:2] != 2'b01 || in_rt[3:2] != 2'b00;
      5'd3:       range_bad = in_rs[3:2] != 2'b00 || in_rt[3:2] != 2'b10;
      5'd4:       range_bad = in_rs[3:2] != 2'b01 || in_rd[3:2] != 2'b00;
      5'd6:       range_bad = in_rs > 4'd11;
      5'd7:       range_bad = in_rd > 4'd11;
      5'd8, 5'd10: range_bad = in_rs[3:2] != 2'b01 || in_rt[3:2] != 2'b00 || in_rd[3:2] != 2'b10;
      5'd9:       range_bad = in_rd[3:2] != 2'b10 || in_rs[3:2] != 2'b00 || in_imm[5:2] != 4'd0;
      5'd11:      range_bad = in_rd < 4'd1 || in_rd > 4'd8 || in_rs < 4'd5 || in_rs > 4'd11;
      default:    range_bad = 1'b0;
    endcase
  end
`else
  assign range_bad = 1'b0;
`endif
  // The address register advances at each accept after the first, so in DONE/ERR it
  // still points at the last word actually written.
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    word_d = word_q;
    cnt_d = cnt_q;
    code_d = code_q;
    case (state_q)
      IDLE, DONE, ERR: if (start) begin
        state_d = LOAD;
        addr_d = base_addr;
        cnt_d = '0;
        code_d = 2'd0;
      end
      LOAD: if (in_valid) begin
        state_d = (mnem_bad || range_bad) ? ERR : WRITE;
        code_d = mnem_bad ? 2'd1 : range_bad ? 2'd2 : code_q;
        word_d = (mnem_bad || range_bad) ? word_q : enc;
        addr_d = (mnem_bad || range_bad || cnt_q == '0) ? addr_q : addr_q + 1'b1;
      end
      WRITE: begin
        cnt_d = cnt_q + 1'b1;
        state_d = (word_q == HALT) ? DONE : (&addr_q) ? ERR : LOAD;
        code_d = (word_q != HALT && &addr_q) ? 2'd3 : code_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      word_q <= '0;
      cnt_q <= '0;
      code_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      word_q <= word_d;
      cnt_q <= cnt_d;
      code_q <= code_d;
    end
  end
  assign in_ready = state_q == LOAD;
  assign imem_we = state_q == WRITE;
  assign imem_addr = addr_q;
  assign imem_wdata = word_q;
  assign busy = state_q == LOAD || state_q == WRITE;
  assign done = state_q == DONE;
  assign err = state_q == ERR;
  assign err_code = code_q;
  assign word_count = cnt_q;
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: scoreboard bench for instr_encoder with directed vectors
module tb_instr_encoder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [7:0] base_addr = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [4:0] in_mnem = '0;
  logic [3:0] in_rs = '0, in_rt = '0, in_rd = '0;
  logic [5:0] in_imm = '0;
  logic imem_we;
  logic [7:0] imem_addr;
  logic [8:0] imem_wdata;
  logic busy, done, err;
  logic [1:0] err_code;
  logic [8:0] word_count;
  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q[$];

  instr_encoder dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_mnem(in_mnem),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [7:0] a, input logic [8:0] w);
    exp_q.push_back({a, w});
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  initial forever begin
    logic [16:0] e;
    @(negedge clk);
    if (imem_we) begin
      if (exp_q.size() == 0) chk("unexpected_write", {imem_addr, imem_wdata}, 0);
      else begin
        e = exp_q.pop_front();
        chk("wr_addr", imem_addr, e[16:9]);
        chk("wr_data", imem_wdata, e[8:0]);
      end
    end
  end

  task automatic do_start(input logic [7:0] b);
    @(negedge clk);
    start = 1'b1;
    base_addr = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [4:0] m, input logic [3:0] rs, input logic [3:0] rt,
                      input logic [3:0] rd, input logic [5:0] imm);
    int n = 0;
    in_mnem = m; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("ready_timeout", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, in_ready, 0);
    chk({tag, "_we"}, imem_we, 0);
    chk({tag, "_addr"}, imem_addr, 0);
    chk({tag, "_wdata"}, imem_wdata, 0);
    chk({tag, "_flags"}, {busy, done, err, err_code}, 0);
    chk({tag, "_count"}, word_count, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk_idle("reset");
    reset = 1'b0;
    do_start(8'h10);
    chk("start_ready", in_ready, 1);
    chk("start_busy", busy, 1);
    expect_wr(8'h10, 9'b010_01_10_11);
    send(5'd8, 4'd5, 4'd2, 4'd11, 6'd0);
    @(negedge clk);
    chk("add_count", word_count, 1);
    chk("add_back_to_load", in_ready, 1);
    // Stream from a clean state.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    do_start(8'h10);
    expect_wr(8'h10, 9'b000_01_01_11);
    send(5'd3, 4'd1, 4'd9, 4'd0, 6'd0);
    expect_wr(8'h11, 9'b011_00_11_10);
    send(5'd9, 4'd3, 4'd0, 4'd8, 6'd2);
    expect_wr(8'h12, 9'b101_011_010);
    send(5'd11, 4'd7, 4'd0, 4'd4, 6'd0);
    expect_wr(8'h13, 9'b111_0000_11);
    send(5'd16, 4'd0, 4'd0, 4'd0, 6'd0);
    @(negedge clk);
    chk("stream_done", {done, err, busy}, 3'b100);
    chk("stream_count", word_count, 4);
    chk("stream_addr_hold", imem_addr, 8'h13);
    // Out-of-range AND operand.
    do_start(8'h20);
    chk("restart_done_clr", done, 0);
    chk("restart_count_clr", word_count, 0);
`ifdef INSTR_ENC_RANGE_CHECK_EN
    send(5'd0, 4'd2, 4'd1, 4'd0, 6'd0);
    chk("range_err", {err, err_code}, 3'b110);
    chk("range_count", word_count, 0);
`else
    expect_wr(8'h20, 9'b000_10_01_00);
    send(5'd0, 4'd2, 4'd1, 4'd0, 6'd0);
    expect_wr(8'h21, 9'b111_0000_11);
    send(5'd16, 4'd0, 4'd0, 4'd0, 6'd0);
    @(negedge clk);
    chk("norange_done", {done, err}, 2'b10);
    chk("norange_count", word_count, 2);
`endif
    // Illegal mnemonic.
    do_start(8'h30);
    send(5'd20, 4'd5, 4'd2, 4'd11, 6'd0);
    chk("mnem_err", {err, err_code}, 3'b101);
    chk("mnem_count", word_count, 0);
    do_start(8'h40);
    chk("restart_err_clr", {err, err_code}, 0);
    expect_wr(8'h40, 9'b001_10_11_01);
    send(5'd5, 4'd6, 4'd3, 4'd0, 6'd0);
    expect_wr(8'h41, 9'b001_11_10_00);
    send(5'd4, 4'd7, 4'd0, 4'd2, 6'd0);
    expect_wr(8'h42, 9'b100_00_11_10);
    send(5'd10, 4'd4, 4'd3, 4'd10, 6'd0);
    expect_wr(8'h43, 9'b111_01_01_01);
    send(5'd14, 4'd5, 4'd1, 4'd0, 6'd0);
    expect_wr(8'h44, 9'b001_1001_11);
    send(5'd7, 4'd0, 4'd0, 4'd9, 6'd0);
    expect_wr(8'h45, 9'b000_00_00_01);
    send(5'd1, 4'd4, 4'd0, 4'd0, 6'd0);
    expect_wr(8'h46, 9'b111_0000_11);
    send(5'd16, 4'd0, 4'd0, 4'd0, 6'd0);
    @(negedge clk);
    chk("mix_done", {done, err, err_code}, 4'b1000);
    chk("mix_count", word_count, 7);
    // Address overflow.
    do_start(8'hFF);
    expect_wr(8'hFF, 9'b110_101010);
    send(5'd12, 4'd0, 4'd0, 4'd0, 6'h2A);
    @(negedge clk);
    chk("ovf_err", {done, err, err_code}, 4'b0111);
    chk("ovf_addr", imem_addr, 8'hFF);
    chk("ovf_count", word_count, 1);
    // Reset while the write strobe is high.
    do_start(8'h50);
    expect_wr(8'h50, 9'b001_1011_10);
    send(5'd6, 4'd11, 4'd0, 4'd0, 6'd0);
    #2 reset = 1'b1;
    #1 chk_idle("midwrite");
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle("post_reset");
    chk("sb_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Program-loading encoder for the 9-bit core: accepts one symbolic instruction per handshake (mnemonic plus register/immediate operands), validates operands against the register-bank constraints of each instruction format, packs the 9-bit instruction word, and writes it into instruction memory at an auto-incrementing address. It sits between the testbench/host loader and the instruction ROM/RAM write port, and produces exactly the words the core's instruction decoder consumes.

## Interface
- num_regs, 12, register file size; register operands are $clog2(num_regs) = 4 bits
- instr_width, 9, instruction word width
- pc_width, 8, instruction memory address width
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; returns block to IDLE
- start  in  1  pulse; begins a load at base_addr (honoured in IDLE/DONE/ERR only)
- base_addr  in  pc_width  first write address
- in_valid  in  1  operand bundle valid
- in_ready  out  1  encoder can accept a bundle
- in_mnem  in  5  mnemonic code (0–16 legal, 17–31 illegal)
- in_rs, in_rt, in_rd  in  4  register numbers
- in_imm  in  6  immediate
- imem_we  out  1  instruction memory write strobe
- imem_addr  out  pc_width  write address
- imem_wdata  out  instr_width  encoded word
- busy  out  1  state is LOAD or WRITE
- done  out  1  HALT written, load complete (level, held until start/reset)
- err  out  1  load aborted (level, held until start/reset)
- err_code  out  2  0 none, 1 illegal mnemonic, 2 operand out of range, 3 address overflow
- word_count  out  pc_width+1  words written since start

## Operation
- States: IDLE, LOAD, WRITE, DONE, ERR. IDLE/DONE/ERR + start -> LOAD; clears done, err, err_code, word_count; address register <= base_addr.
- LOAD: in_ready=1. Transfer when in_valid&&in_ready: encode and check in the same cycle, register word; legal -> WRITE, illegal -> ERR with err_code, nothing written.
- WRITE: imem_we=1 for exactly one cycle, imem_addr=address register, imem_wdata=registered word; word_count+1. Then: HALT -> DONE; address == 2^pc_width-1 and not HALT -> ERR code 3; else address+1, -> LOAD.
- Encodings (fields MSB..LSB, n-k means operand minus bank base; allowed ranges checked):
  - 0 AND/1 SLT/2 OR: 000, rs-4 (rs 4–7), rt (0–3), sub 00/01/10
  - 3 BEQ: 000, rs (0–3), rt-8 (8–11), 11
  - 4 LW: 001, rs-4 (4–7), rd (0–3), 00; 5 SW: 001, rs-4, rt (0–3), 01
  - 6 INC: 001, rs[3:0] (0–11), 10; 7 CLR: 001, rd[3:0] (0–11), 11
  - 8 ADD/10 SUB: 010/100, rs-4 (4–7), rt (0–3), rd-8 (8–11)
  - 9 ADDI: 011, rd-8 (8–11), rs (0–3), imm[1:0] (imm 0–3)
  - 11 TR: 101, rd-1 (1–8) 3 bits, rs-5 (5–11) 3 bits
  - 12 JR: 110, imm[5:0]
  - 13 SRL/14 SRA/15 SLL: 111, rs-4 (4–7), rt (0–3), 00/01/10
  - 16 HALT: 9'b111_0000_11
- Unused operands are don't-care and never checked.
- Mnemonic check (code 1) has priority over range check (code 2).

## Timing
- Reset values: state IDLE, in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, busy 0, done 0, err 0, err_code 0, word_count 0.
- start to in_ready high: 1 cycle. Accept at edge N -> imem_we high in cycle N+1. Throughput one word per 2 cycles; in_ready low in WRITE.
- done/err assert the cycle after the final WRITE or the rejecting accept.
- start during LOAD/WRITE ignored. reset mid-WRITE: strobe drops immediately (async), no partial state survives.
- imem_addr holds last written address in DONE/ERR.

## Configuration
- INSTR_ENC_RANGE_CHECK_EN defined: operand range checks active, err_code 2 possible.
- Undefined: no range checks; operands are offset-subtracted and truncated to field width (e.g. ADD rs=9 encodes rs field 01); illegal mnemonic and overflow checks remain.

## Test plan
- start, base_addr=0x10; ADD rs=5 rt=2 rd=11 -> imem_addr 0x10, wdata 9'b010_01_10_11, word_count 1, back to LOAD.
- Stream BEQ rs=1 rt=9, ADDI rs=3 rd=8 imm=2, TR rd=4 rs=7, HALT -> words 000_01_01_11, 011_00_11_10, 101_011_010, 111_0000_11 at 0x10..0x13; done=1, word_count 4.
- With macro: AND rs=2 rt=1 -> err=1, err_code 2, no imem_we; without macro same input writes 000_10_01_00.
- in_mnem=20 -> err_code 1 regardless of macro; subsequent start clears err and loads normally.
- base_addr=0xFF, JR imm=0x2A -> word 110_101010 written at 0xFF, then err_code 3; reset asserted mid-WRITE on a later run -> imem_we 0 immediately, all outputs at reset values.
